// File: rtl/synth_pkg.sv
// Shared constants and helpers for the note synthesiser blocks: voice-select width,
// signed sample limits and mix-mode encodings.
package synth_pkg;

  typedef enum logic {
    MixAvg = 1'b0,
    MixSat = 1'b1
  } mix_mode_e;

  localparam int unsigned PhaseW = 20;
  localparam int unsigned StepW  = 20;

  function automatic int unsigned vsel_width(input int unsigned num_voices);
    return (num_voices <= 2) ? 1 : $clog2(num_voices);
  endfunction

  function automatic longint sample_max(input int unsigned width);
    return (longint'(1) <<< (width - 1)) - 1;
  endfunction

  function automatic longint sample_min(input int unsigned width);
    return -(longint'(1) <<< (width - 1));
  endfunction

endpackage

// File: rtl/note_voice.sv
// One synthesiser voice: note/duration latch, beat countdown, frequency ROM,
// gated phase step and sine table reader.
module note_voice
  import synth_pkg::*;
#(
  parameter int unsigned NOTE_W   = 6,
  parameter int unsigned DUR_W    = 6,
  parameter int unsigned SAMPLE_W = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       play_enable_i,
  input  logic                       load_i,
  input  logic [NOTE_W-1:0]          note_i,
  input  logic [DUR_W-1:0]           dur_i,
  input  logic                       beat_i,
  input  logic                       gen_i,
  output logic                       done_o,
  output logic signed [SAMPLE_W-1:0] sample_o,
  output logic                       sample_ready_o
);

  logic [NOTE_W-1:0]          note_q, note_d;
  logic [DUR_W-1:0]           cnt_q, cnt_d;
  logic                       done_q, done_d;
  logic [StepW-1:0]           step_q, step_d, rom_step;
  logic [PhaseW-1:0]          phase_q, phase_d;
  logic signed [SAMPLE_W-1:0] sample_q, sample_d, tone;
  logic signed [15:0]         sine16;
  logic                       ready_q, ready_d;
  logic [11:0]                base;
  int unsigned                note_idx, octave;

  // A load takes priority over a coincident beat, which is then dropped.
  always_comb begin
    note_d = note_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      note_d = note_i;
      cnt_d  = dur_i;
    end else if (beat_i && play_enable_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - DUR_W'(1);
    end
    done_d = (cnt_d == '0);
  end

  always_comb begin
    note_idx = 32'(note_q);
    octave   = note_idx / 12;
    if (octave > 7) octave = 7;
    base = '0;
    case (note_idx % 12)
      0:       base = 12'd1097;
      1:       base = 12'd1163;
      2:       base = 12'd1232;
      3:       base = 12'd1305;
      4:       base = 12'd1383;
      5:       base = 12'd1465;
      6:       base = 12'd1552;
      7:       base = 12'd1644;
      8:       base = 12'd1742;
      9:       base = 12'd1845;
      10:      base = 12'd1955;
      11:      base = 12'd2071;
      default: base = '0;
    endcase
    rom_step = StepW'(base) << octave;
    step_d   = (play_enable_i && (cnt_q != '0) && (note_q != '0)) ? rom_step : '0;
  end

  always_comb begin
    case (phase_q[PhaseW-1 -: 4])
      4'd0:    sine16 = 16'sd0;
      4'd1:    sine16 = 16'sd11481;
      4'd2:    sine16 = 16'sd21213;
      4'd3:    sine16 = 16'sd27716;
      4'd4:    sine16 = 16'sd30000;
      4'd5:    sine16 = 16'sd27716;
      4'd6:    sine16 = 16'sd21213;
      4'd7:    sine16 = 16'sd11481;
      4'd8:    sine16 = 16'sd0;
      4'd9:    sine16 = -16'sd11481;
      4'd10:   sine16 = -16'sd21213;
      4'd11:   sine16 = -16'sd27716;
      4'd12:   sine16 = -16'sd30000;
      4'd13:   sine16 = -16'sd27716;
      4'd14:   sine16 = -16'sd21213;
      default: sine16 = -16'sd11481;
    endcase
    // Rescale the 16-bit table entry to the configured sample width.
    tone = SAMPLE_W'((longint'(sine16) <<< SAMPLE_W) >>> 16);
  end

  // A paused voice keeps its phase, so its contribution repeats; finished or rest notes are silent.
  always_comb begin
    phase_d  = phase_q;
    sample_d = sample_q;
    ready_d  = 1'b0;
    if (gen_i) begin
      ready_d  = 1'b1;
      phase_d  = phase_q + step_q;
      sample_d = ((note_q == '0) || (cnt_q == '0)) ? '0 : tone;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      note_q   <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b1;
      step_q   <= '0;
      phase_q  <= '0;
      sample_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      note_q   <= note_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      step_q   <= step_d;
      phase_q  <= phase_d;
      sample_q <= sample_d;
      ready_q  <= ready_d;
    end
  end

  assign done_o         = done_q;
  assign sample_o       = sample_q;
  assign sample_ready_o = ready_q;

endmodule

// File: rtl/note_mixer.sv
// Multi-voice note player: routes note loads to voices and mixes their samples
// by averaging or saturating summation.
module note_mixer
  import synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 2,
  parameter int unsigned NOTE_W     = 6,
  parameter int unsigned DUR_W      = 6,
  parameter int unsigned SAMPLE_W   = 16,
  localparam int unsigned VSEL_W    = vsel_width(NUM_VOICES)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       play_enable,
  input  logic                       load_new_note,
  input  logic [VSEL_W-1:0]          voice_sel,
  input  logic [NOTE_W-1:0]          note_to_load,
  input  logic [DUR_W-1:0]           duration_to_load,
  input  logic                       beat,
  input  logic                       mix_mode,
  input  logic                       generate_next_sample,
  output logic [NUM_VOICES-1:0]      done_with_note,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       new_sample_ready
);

  localparam int unsigned SumW = SAMPLE_W + VSEL_W;
  localparam logic signed [SumW-1:0]     SumMax = SumW'(sample_max(SAMPLE_W));
  localparam logic signed [SumW-1:0]     SumMin = SumW'(sample_min(SAMPLE_W));
  localparam logic signed [SAMPLE_W-1:0] OutMax = SAMPLE_W'(sample_max(SAMPLE_W));
  localparam logic signed [SAMPLE_W-1:0] OutMin = SAMPLE_W'(sample_min(SAMPLE_W));

  logic signed [SAMPLE_W-1:0] voice_sample [NUM_VOICES];
  logic [NUM_VOICES-1:0]      voice_ready;
  logic signed [SumW-1:0]     sum;
  logic signed [SAMPLE_W-1:0] mix_q, mix_d;
  logic                       ready_q, ready_d;

  // Out-of-range voice_sel values match no voice, so such loads fall away.
  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    logic load_v;
    assign load_v = load_new_note && (voice_sel == VSEL_W'(v));

    note_voice #(
      .NOTE_W  (NOTE_W),
      .DUR_W   (DUR_W),
      .SAMPLE_W(SAMPLE_W)
    ) u_voice (
      .clk_i         (clk),
      .rst_i         (reset),
      .play_enable_i (play_enable),
      .load_i        (load_v),
      .note_i        (note_to_load),
      .dur_i         (duration_to_load),
      .beat_i        (beat),
      .gen_i         (generate_next_sample),
      .done_o        (done_with_note[v]),
      .sample_o      (voice_sample[v]),
      .sample_ready_o(voice_ready[v])
    );
  end

  always_comb begin
    sum = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      sum = sum + SumW'(voice_sample[v]);
    end
  end

  always_comb begin
    mix_d   = mix_q;
    ready_d = 1'b0;
    if (&voice_ready) begin
      ready_d = 1'b1;
      if (mix_mode == MixAvg) begin
        mix_d = sum[SumW-1:VSEL_W];
      end else if (sum > SumMax) begin
        mix_d = OutMax;
      end else if (sum < SumMin) begin
        mix_d = OutMin;
      end else begin
        mix_d = sum[SAMPLE_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mix_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      mix_q   <= mix_d;
      ready_q <= ready_d;
    end
  end

  assign sample_out       = mix_q;
  assign new_sample_ready = ready_q;

endmodule

// File: tb/tb_note_mixer.sv
// Directed bench for note_mixer: countdown, pause, load/beat collision, both mix modes,
// rest notes and asynchronous reset during a sample request.
module tb_note_mixer;

  localparam int unsigned NumVoices = 2;
  localparam int unsigned NoteW     = 6;
  localparam int unsigned DurW      = 6;
  localparam int unsigned SampleW   = 16;
  localparam int unsigned VselW     = 1;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      play_enable;
  logic                      load_new_note;
  logic [VselW-1:0]          voice_sel;
  logic [NoteW-1:0]          note_to_load;
  logic [DurW-1:0]           duration_to_load;
  logic                      beat;
  logic                      mix_mode;
  logic                      generate_next_sample;
  logic [NumVoices-1:0]      done_with_note;
  logic signed [SampleW-1:0] sample_out;
  logic                      new_sample_ready;

  int checks   = 0;
  int failures = 0;

  note_mixer #(
    .NUM_VOICES(NumVoices),
    .NOTE_W    (NoteW),
    .DUR_W     (DurW),
    .SAMPLE_W  (SampleW)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .play_enable         (play_enable),
    .load_new_note       (load_new_note),
    .voice_sel           (voice_sel),
    .note_to_load        (note_to_load),
    .duration_to_load    (duration_to_load),
    .beat                (beat),
    .mix_mode            (mix_mode),
    .generate_next_sample(generate_next_sample),
    .done_with_note      (done_with_note),
    .sample_out          (sample_out),
    .new_sample_ready    (new_sample_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int v, input int note, input int dur, input bit with_beat);
    voice_sel        = VselW'(v);
    note_to_load     = NoteW'(note);
    duration_to_load = DurW'(dur);
    load_new_note    = 1'b1;
    beat             = with_beat;
    @(negedge clk);
    load_new_note    = 1'b0;
    beat             = 1'b0;
  endtask

  task automatic do_beat();
    beat = 1'b1;
    @(negedge clk);
    beat = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic get_sample(input string tag, output int s);
    int waited;
    waited = 0;
    generate_next_sample = 1'b1;
    @(negedge clk);
    generate_next_sample = 1'b0;
    while (!new_sample_ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_ready"}, int'(new_sample_ready), 1);
    chk({tag, "_latency"}, waited, 1);
    s = int'(sample_out);
    @(negedge clk);
    chk({tag, "_pulse"}, int'(new_sample_ready), 0);
  endtask

  initial begin
    int s;
    logic seen;
    reset                = 1'b1;
    play_enable          = 1'b0;
    load_new_note        = 1'b0;
    voice_sel            = '0;
    note_to_load         = '0;
    duration_to_load     = '0;
    beat                 = 1'b0;
    mix_mode             = 1'b0;
    generate_next_sample = 1'b0;
    cyc(2);
    chk("rst_done", int'(done_with_note), 3);
    chk("rst_sample", int'(sample_out), 0);
    chk("rst_ready", int'(new_sample_ready), 0);

    // Countdown of 3 beats; load accepted in the first cycle out of reset.
    reset       = 1'b0;
    play_enable = 1'b1;
    load(0, 10, 3, 1'b0);
    chk("a_load_done", int'(done_with_note), 2);
    do_beat();
    do_beat();
    chk("a_beat2_done", int'(done_with_note), 2);
    do_beat();
    chk("a_beat3_done", int'(done_with_note), 3);
    get_sample("a_after", s);
    chk("a_after_sample", s, 0);

    // Pause mid-note with 2 beats remaining.
    apply_reset();
    load(0, 60, 4, 1'b0);
    cyc(2);
    get_sample("b_s0", s);
    get_sample("b_s1", s);
    get_sample("b_s2", s);
    chk("b_s2_val", s, 5740);
    do_beat();
    do_beat();
    chk("b_two_left", int'(done_with_note), 2);
    play_enable = 1'b0;
    cyc(2);
    repeat (5) do_beat();
    chk("b_paused_done", int'(done_with_note), 2);
    get_sample("b_p0", s);
    chk("b_p0_val", s, 5740);
    get_sample("b_p1", s);
    chk("b_p1_val", s, 5740);
    play_enable = 1'b1;
    cyc(1);
    do_beat();
    chk("b_resume1_done", int'(done_with_note), 2);
    do_beat();
    chk("b_resume2_done", int'(done_with_note), 3);
    get_sample("b_end", s);
    chk("b_end_val", s, 0);

    // Load and beat on the same edge: the beat is dropped.
    apply_reset();
    load(1, 12, 4, 1'b1);
    chk("c_load_done", int'(done_with_note), 1);
    repeat (3) do_beat();
    chk("c_beat3_done", int'(done_with_note), 1);
    do_beat();
    chk("c_beat4_done", int'(done_with_note), 3);

    // Both voices in phase at the sine peak/trough; saturate vs average.
    apply_reset();
    mix_mode = 1'b1;
    load(0, 60, 63, 1'b0);
    load(1, 60, 63, 1'b0);
    cyc(2);
    for (int k = 0; k < 9; k++) begin
      get_sample("d_walk", s);
      if (k == 2) chk("d_k2_inrange", s, 22962);
    end
    chk("d_k8_sat_pos", s, 32767);
    mix_mode = 1'b0;
    get_sample("d_k9", s);
    chk("d_k9_avg_pos", s, 30000);
    mix_mode = 1'b1;
    for (int k = 10; k < 24; k++) get_sample("d_walk2", s);
    chk("d_k23_sat_neg", s, -32768);
    mix_mode = 1'b0;
    get_sample("d_k24", s);
    chk("d_k24_avg_neg", s, -30000);

    // Reset between sample request and ready.
    generate_next_sample = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    generate_next_sample = 1'b0;
    chk("e_rst_sample", int'(sample_out), 0);
    chk("e_rst_done", int'(done_with_note), 3);
    chk("e_rst_ready", int'(new_sample_ready), 0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | new_sample_ready;
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | new_sample_ready;
    end
    chk("e_no_ready", int'(seen), 0);

    // Rest notes are silent even with a non-zero held phase.
    load(0, 60, 63, 1'b0);
    cyc(2);
    get_sample("f_s0", s);
    get_sample("f_s1", s);
    get_sample("f_s2", s);
    chk("f_s2_val", s, 5740);
    load(0, 0, 5, 1'b0);
    load(1, 0, 5, 1'b0);
    cyc(2);
    chk("f_load_done", int'(done_with_note), 0);
    get_sample("f_r0", s);
    chk("f_r0_val", s, 0);
    get_sample("f_r1", s);
    chk("f_r1_val", s, 0);
    repeat (4) do_beat();
    chk("f_beat4_done", int'(done_with_note), 0);
    do_beat();
    chk("f_beat5_done", int'(done_with_note), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
